// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder with registered sum, carry-out and group
// propagate/generate outputs for cascading into a higher-level lookahead unit.
module cla_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    logic [3:0] sum_d, sum_q;
    logic       cout_d, cout_q;
    logic       pg_d, pg_q;
    logic       gg_d, gg_q;

    // Every carry is a flat sum of products of p, g and cin; no carry feeds another.
    always_comb begin
        p = a ^ b;
        g = a & b;

        c[0] = cin;
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);

        sum_d  = p ^ c[3:0];
        cout_d = c[4];
        pg_d   = p[3] & p[2] & p[1] & p[0];
        gg_d   = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
    end

    // Synchronous reset wins over operands presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 4'h0;
            cout_q <= 1'b0;
            pg_q   <= 1'b0;
            gg_q   <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            pg_q   <= pg_d;
            gg_q   <= gg_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign pg   = pg_q;
    assign gg   = gg_q;

endmodule

// File: tb/tb_cla_4bit.sv
// Directed and exhaustive pipelined checks of cla_4bit against a + b + cin,
// including reset priority, mid-stream reset and synchronous-only reset behaviour.
module tb_cla_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       pg;
    logic       gg;

    int n_cmp;
    int n_err;

    cla_4bit dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .pg   (pg),
        .gg   (gg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                         input logic vr);
        a   = va;
        b   = vb;
        cin = vc;
        rst = vr;
    endtask

    // Wait for the next edge and compare with a hand-given expectation.
    task automatic expect_vals(input string tag, input logic [4:0] e_res,
                               input logic e_pg, input logic e_gg);
        @(posedge clk);
        #1;
        check({tag, ".res"}, {3'b000, cout, sum}, {3'b000, e_res});
        check({tag, ".pg"}, {7'b0, pg}, {7'b0, e_pg});
        check({tag, ".gg"}, {7'b0, gg}, {7'b0, e_gg});
    endtask

    // Arithmetic model for the currently driven operands, checked one edge later.
    task automatic expect_model(input string tag);
        logic [4:0] e_res;
        logic       e_pg;
        logic       e_gg;
        e_res = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        e_pg  = ((a ^ b) == 4'hF);
        e_gg  = (({1'b0, a} + {1'b0, b}) > 5'd15);
        @(posedge clk);
        #1;
        check({tag, ".res"}, {3'b000, cout, sum}, {3'b000, e_res});
        check({tag, ".pg"}, {7'b0, pg}, {7'b0, e_pg});
        check({tag, ".gg"}, {7'b0, gg}, {7'b0, e_gg});
        check({tag, ".inv"}, {7'b0, cout}, {7'b0, e_gg | (e_pg & cin)});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        drive(4'hF, 4'hF, 1'b1, 1'b1);
        expect_vals("reset", 5'h00, 1'b0, 1'b0);

        drive(4'hE, 4'h1, 1'b0, 1'b0);
        expect_vals("basic", 5'h0F, 1'b1, 1'b0);

        drive(4'hE, 4'h1, 1'b1, 1'b0);
        expect_vals("wrap_cin", 5'h10, 1'b1, 1'b0);

        drive(4'h8, 4'h8, 1'b0, 1'b0);
        expect_vals("msb_gen", 5'h10, 1'b0, 1'b1);

        drive(4'h0, 4'h0, 1'b1, 1'b0);
        expect_vals("cin_only", 5'h01, 1'b0, 1'b0);

        drive(4'hF, 4'hF, 1'b1, 1'b0);
        expect_vals("max", 5'h1F, 1'b0, 1'b1);

        // Raising rst between edges must not disturb the held outputs.
        rst = 1'b1;
        #2;
        check("rst_async.res", {3'b000, cout, sum}, 8'h1F);
        check("rst_async.gg", {7'b0, gg}, 8'h01);
        @(posedge clk);
        #1;
        check("rst_sync.res", {3'b000, cout, sum}, 8'h00);
        check("rst_sync.gg", {7'b0, gg}, 8'h00);

        // Exhaustive, back-to-back, with one reset pulse mid-stream.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            if (i == 200) begin
                drive(v[3:0], v[7:4], v[8], 1'b1);
                expect_vals("mid_rst", 5'h00, 1'b0, 1'b0);
            end else begin
                drive(v[3:0], v[7:4], v[8], 1'b0);
                expect_model($sformatf("vec%0d", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cla_4bit.md
CLA_4BIT -- requirements
Module: cla_4bit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 4 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 a  input  4  addend A, unsigned.
REQ-005 b  input  4  addend B, unsigned.
REQ-006 cin  input  1  carry-in to bit 0.
REQ-007 sum  output  4  registered sum bits [3:0].
REQ-008 cout  output  1  registered carry-out of bit 3.
REQ-009 pg  output  1  registered group propagate, for cascading into a higher-level lookahead unit.
REQ-010 gg  output  1  registered group generate, for cascading into a higher-level lookahead unit.

Function
REQ-011 Per-bit signals SHALL be p[i] = a[i] XOR b[i] and g[i] = a[i] AND b[i], for i = 0..3.
REQ-012 Internal carries SHALL be computed in parallel lookahead form from p, g and cin, with no ripple chain:
- c1 = g0 | p0·cin
- c2 = g1 | p1·g0 | p1·p0·cin
- c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·cin
- c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·cin
REQ-013 The next sum SHALL be sum[i] = p[i] XOR c[i], where c0 = cin.
REQ-014 The next cout SHALL be c4.
REQ-015 The next pg SHALL be p3·p2·p1·p0.
REQ-016 The next gg SHALL be g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0.
REQ-017 The invariant cout == gg | (pg · cin) SHALL hold on every registered output set.
REQ-018 Arithmetic result: {cout, sum} SHALL equal a + b + cin as a 5-bit unsigned value, range 0..31.
REQ-019 Overflow SHALL wrap modulo 16 in sum, with the excess reported only in cout; no saturation.
REQ-020 Latency SHALL be exactly 1 clock: operands sampled at rising edge N appear on the outputs after edge N.
REQ-021 Outputs SHALL hold until the next rising edge.
REQ-022 The block SHALL accept a new operand set every cycle, with no handshake and no stall.
REQ-023 The block SHALL contain no state other than the sum, cout, pg and gg output registers.
REQ-024 All outputs SHALL be driven directly from flip-flops, with no combinational path from inputs to outputs.

Reset
REQ-025 When rst = 1 at a rising edge, the block SHALL load sum = 4'h0, cout = 0, pg = 0 and gg = 0.
REQ-026 Reset SHALL take priority over the operands presented in the same cycle.
REQ-027 rst SHALL have no asynchronous effect.
REQ-028 The first rising edge with rst = 0 SHALL register the result of the operands present at that edge.
REQ-029 Asserting reset mid-stream SHALL discard the in-flight result; outputs read 0 after that edge.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset: rst = 1 with a = F, b = F, cin = 1 -> after the edge, sum = 0, cout = 0, pg = 0, gg = 0.
- Basic add: a = E, b = 1, cin = 0 -> one cycle later, sum = F, cout = 0, pg = 1, gg = 0.
- Wrap via cin: a = E, b = 1, cin = 1 -> sum = 0, cout = 1, pg = 1, gg = 0.
- Maximum: a = F, b = F, cin = 1 -> sum = F, cout = 1, pg = 0, gg = 1.
- MSB generate: a = 8, b = 8, cin = 0 -> sum = 0, cout = 1, gg = 1; also a = 0, b = 0, cin = 1 -> sum = 1, cout = 0.
- Exhaustive and pipelined: back-to-back random/exhaustive 512 combinations -> each result matches a + b + cin exactly one cycle later and REQ-017 holds; rst pulsed mid-stream -> zeros for exactly that cycle, then correct results resume.
